irq_entry_sequencer: RTL

- Multi-cycle controller that sequences interrupt entry and exit for the 5-stage 16-bit pipeline.
- On a request it freezes fetch and saves the CCR to the shadow flag register.
- It then injects three synthetic instructions into decode (push PC low, push PC high, load vector) and waits for the pipeline to settle.
- It holds the in-service state until an RTI commits in write-back, then restores the flags.
- Sits between the fetch stage / IF-ID buffer and the decode-stage instruction selector.

---
 rtl/irq_entry_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/irq_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_entry_sequencer
// Description : Interrupt entry/exit sequencer for the 5-stage 16-bit
//               pipeline. Freezes fetch, saves the CCR, injects push-PC-lo,
//               push-PC-hi and load-vector instructions into decode, waits
//               for the pipeline to settle, then holds in-service until an
//               RTI commits in write-back and the flags are restored.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_entry_sequencer #(
    parameter logic [4:0] INT_OPCODE    = 5'b11110,
    parameter int         SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        defer,
    input  logic        rti_commit,
    output logic        stall_fetch,
    output logic        inj_valid,
    output logic [15:0] inj_instr,
    output logic        save_flags,
    output logic        restore_flags,
    output logic        irq_ack,
    output logic        in_service,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAVE    = 3'd1;
    localparam logic [2:0] S_PUSH_LO = 3'd2;
    localparam logic [2:0] S_PUSH_HI = 3'd3;
    localparam logic [2:0] S_VEC     = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;
    localparam logic [2:0] S_ISR     = 3'd6;

    localparam logic [2:0] c_SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       r_pending;
    logic [2:0] r_settle_cnt;
    logic [2:0] w_settle_cnt_next;
    logic       r_ack;
    logic       w_leave_idle;
    logic [2:0] w_step;

    // Leaving IDLE consumes the request (live irq or the merged pending one).
    assign w_leave_idle = (r_state == S_IDLE) && (irq || r_pending) && !defer;

    // State register plus pending, settle counter and first-ISR-cycle flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_settle_cnt <= 3'd0;
            r_ack        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_settle_cnt <= w_settle_cnt_next;
            // A request that does not start entry this edge is remembered;
            // repeated pulses merge into a single pending request.
            if (w_leave_idle) begin
                r_pending <= 1'b0;
            end else if (irq) begin
                r_pending <= 1'b1;
            end
            r_ack <= (r_state == S_SETTLE) && (w_next_state == S_ISR);
        end
    end

    // Next-state and settle-counter logic.
    always_comb begin
        w_next_state      = r_state;
        w_settle_cnt_next = r_settle_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_leave_idle) begin
                    w_next_state = S_SAVE;
                end
            end
            S_SAVE:    w_next_state = S_PUSH_LO;
            S_PUSH_LO: w_next_state = S_PUSH_HI;
            S_PUSH_HI: w_next_state = S_VEC;
            S_VEC: begin
                w_next_state      = S_SETTLE;
                w_settle_cnt_next = c_SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (r_settle_cnt == 3'd0) begin
                    w_next_state = S_ISR;
                end else begin
                    w_settle_cnt_next = r_settle_cnt - 3'd1;
                end
            end
            S_ISR: begin
                if (rti_commit) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: Moore on state/registers, except restore_flags which
    // follows rti_commit combinationally while in service.
    always_comb begin
        stall_fetch   = 1'b0;
        inj_valid     = 1'b0;
        save_flags    = 1'b0;
        w_step        = 3'b000;
        case (r_state)
            S_SAVE: begin
                stall_fetch = 1'b1;
                save_flags  = 1'b1;
            end
            S_PUSH_LO: begin
                stall_fetch = 1'b1;
                inj_valid   = 1'b1;
                w_step      = 3'b001;
            end
            S_PUSH_HI: begin
                stall_fetch = 1'b1;
                inj_valid   = 1'b1;
                w_step      = 3'b010;
            end
            S_VEC: begin
                stall_fetch = 1'b1;
                inj_valid   = 1'b1;
                w_step      = 3'b011;
            end
            S_SETTLE: begin
                stall_fetch = 1'b1;
            end
            default: begin
                stall_fetch = 1'b0;
            end
        endcase
        inj_instr     = inj_valid ? {INT_OPCODE, 8'b0, w_step} : 16'h0000;
        in_service    = (r_state == S_ISR);
        busy          = (r_state != S_IDLE);
        irq_ack       = r_ack;
        restore_flags = (r_state == S_ISR) && rti_commit;
    end

endmodule
`default_nettype wire
